// File: rtl/icg_enable_ctrl_if.sv
// Bundle between the gated-domain producer and the ICG enable controller.
//   master : producer side; drives req/busy/force_on/scan_en, observes the gate state.
//   slave  : controller side; samples the requests, drives e/te/ack/gate_off_cnt.
//   req          activity request from the upstream producer
//   busy         gated domain still has work in flight
//   force_on     software override holding the gate open
//   scan_en      scan/test enable
//   e            functional enable to the ICG E pin
//   te           test enable to the ICG TE pin
//   ack          gated clock is running and settled
//   gate_off_cnt saturating count of ON-to-OFF transitions
interface icg_enable_ctrl_if #(
  parameter int unsigned EVT_W = 8
);
  logic             req;
  logic             busy;
  logic             force_on;
  logic             scan_en;
  logic             e;
  logic             te;
  logic             ack;
  logic [EVT_W-1:0] gate_off_cnt;

  modport master (
    output req, busy, force_on, scan_en,
    input  e, te, ack, gate_off_cnt
  );

  modport slave (
    input  req, busy, force_on, scan_en,
    output e, te, ack, gate_off_cnt
  );
endinterface

// File: rtl/icg_enable_ctrl.sv
// Enable controller for a negative-edge integrated clock gate. Opens the gate when the domain
// has work, holds it through a wake-up settle window and an idle-hysteresis window, and counts
// gate-off events for power telemetry. Runs on the free-running clock upstream of the ICG.
//   clk : free-running ungated clock
//   rst : synchronous, active-high reset
//   bus : slave side of icg_enable_ctrl_if (requests in, e/te/ack/gate_off_cnt out)
// Every output is a direct flop output, so there is no combinational input-to-output path.
module icg_enable_ctrl #(
  parameter int unsigned IDLE_CYCLES = 8,  // 1..255
  parameter int unsigned WAKE_CYCLES = 2,  // 0..15, 0 skips the wake window
  parameter int unsigned EVT_W       = 8
) (
  input logic               clk,
  input logic               rst,
  icg_enable_ctrl_if.slave  bus
);

  localparam int unsigned WakeLoadInt = (WAKE_CYCLES == 0) ? 0 : WAKE_CYCLES - 1;
  localparam int unsigned IdleLoadInt = (IDLE_CYCLES == 0) ? 0 : IDLE_CYCLES - 1;
  localparam logic [3:0]  WakeLoad    = WakeLoadInt[3:0];
  localparam logic [7:0]  IdleLoad    = IdleLoadInt[7:0];

  typedef enum logic [1:0] {StOff, StWake, StOn, StDrain} state_e;

  state_e           state_q, state_d;
  logic [3:0]       wake_q, wake_d;
  logic [7:0]       idle_q, idle_d;
  logic [EVT_W-1:0] cnt_q, cnt_d;
  logic             e_q, e_d;
  logic             ack_q, ack_d;
  logic             te_q;
  logic             act;

  assign act = bus.req | bus.busy | bus.force_on;

  always_comb begin
    state_d = state_q;
    wake_d  = wake_q;
    idle_d  = idle_q;
    cnt_d   = cnt_q;

    unique case (state_q)
      StOff: begin
        // busy alone never opens the gate; only a real request or the override does
        if (bus.req || bus.force_on) begin
          if (WAKE_CYCLES == 0) begin
            state_d = StOn;
          end else begin
            state_d = StWake;
            wake_d  = WakeLoad;
          end
        end
      end
      StWake: begin
        // act is ignored here: a started wake always completes
        if (wake_q == 4'd0) begin
          state_d = StOn;
        end else begin
          wake_d = wake_q - 4'd1;
        end
      end
      StOn: begin
        if (!act) begin
          state_d = StDrain;
          idle_d  = IdleLoad;
        end
      end
      StDrain: begin
        if (act) begin
          state_d = StOn;
        end else if (idle_q == 8'd0) begin
          state_d = StOff;
          if (cnt_q != {EVT_W{1'b1}}) begin
            cnt_d = cnt_q + 1'b1;
          end
        end else begin
          idle_d = idle_q - 8'd1;
        end
      end
      default: state_d = StOff;
    endcase

    // Outputs are decoded from the next state and registered, so they change on the same edge
    // as the state and stay glitch-free.
    e_d   = (state_d != StOff);
    ack_d = (state_d == StOn) || (state_d == StDrain);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StOff;
      wake_q  <= 4'd0;
      idle_q  <= 8'd0;
      cnt_q   <= '0;
      e_q     <= 1'b0;
      ack_q   <= 1'b0;
      te_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      wake_q  <= wake_d;
      idle_q  <= idle_d;
      cnt_q   <= cnt_d;
      e_q     <= e_d;
      ack_q   <= ack_d;
      te_q    <= bus.scan_en;
    end
  end

  assign bus.e            = e_q;
  assign bus.ack          = ack_q;
  assign bus.te           = te_q;
  assign bus.gate_off_cnt = cnt_q;

endmodule

// File: tb/tb_icg_enable_ctrl.sv
// Scoreboard bench for icg_enable_ctrl. The stimulus process pushes hand-computed expectations
// tagged with the clock edge after which they must hold; a monitor samples on the falling edge
// and pops/compares every expectation that is due.
module tb_icg_enable_ctrl;

  localparam int SigE    = 0;
  localparam int SigAck  = 1;
  localparam int SigTe   = 2;
  localparam int SigCnt  = 3;
  localparam int SigE0   = 4;
  localparam int SigAck0 = 5;

  typedef struct {
    int cyc;
    int test;
    int sig;
    int val;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   cur_test = 0;
  exp_t sb[$];

  icg_enable_ctrl_if #(.EVT_W(8)) bus_a ();
  icg_enable_ctrl_if #(.EVT_W(8)) bus_b ();

  // Main build: IDLE_CYCLES=4, WAKE_CYCLES=2
  icg_enable_ctrl #(
    .IDLE_CYCLES(4),
    .WAKE_CYCLES(2),
    .EVT_W      (8)
  ) u_dut (
    .clk(clk),
    .rst(rst),
    .bus(bus_a)
  );

  // Zero-wake build sharing the same stimulus
  icg_enable_ctrl #(
    .IDLE_CYCLES(4),
    .WAKE_CYCLES(0),
    .EVT_W      (8)
  ) u_dut_w0 (
    .clk(clk),
    .rst(rst),
    .bus(bus_b)
  );

  assign bus_b.req      = bus_a.req;
  assign bus_b.busy     = bus_a.busy;
  assign bus_b.force_on = bus_a.force_on;
  assign bus_b.scan_en  = bus_a.scan_en;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int sample(input int sig);
    case (sig)
      SigE:    return int'(bus_a.e);
      SigAck:  return int'(bus_a.ack);
      SigTe:   return int'(bus_a.te);
      SigCnt:  return int'(bus_a.gate_off_cnt);
      SigE0:   return int'(bus_b.e);
      SigAck0: return int'(bus_b.ack);
      default: return -1;
    endcase
  endfunction

  function automatic string sig_name(input int sig);
    case (sig)
      SigE:    return "e";
      SigAck:  return "ack";
      SigTe:   return "te";
      SigCnt:  return "gate_off_cnt";
      SigE0:   return "e_w0";
      SigAck0: return "ack_w0";
      default: return "?";
    endcase
  endfunction

  // Expect signal sig == val after dly more rising edges (0 = current cycle).
  task automatic expect_at(input int dly, input int sig, input int val);
    exp_t it;
    int   pos;
    it.cyc  = cyc + dly;
    it.test = cur_test;
    it.sig  = sig;
    it.val  = val;
    pos = sb.size();
    for (int i = 0; i < sb.size(); i++) begin
      if (sb[i].cyc > it.cyc) begin
        pos = i;
        break;
      end
    end
    sb.insert(pos, it);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor: compares every due expectation away from the active edge.
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      exp_t it;
      int   act_v;
      it = sb.pop_front();
      act_v = sample(it.sig);
      checks++;
      if (it.cyc < cyc) begin
        errors++;
        $display("FAIL t%0d %s missed check slot at cycle %0d", it.test, sig_name(it.sig), it.cyc);
      end else if (act_v != it.val) begin
        errors++;
        $display("FAIL t%0d %s at cycle %0d: got %0d, expected %0d",
                 it.test, sig_name(it.sig), cyc, act_v, it.val);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst            = 1'b1;
    bus_a.req      = 1'b0;
    bus_a.busy     = 1'b0;
    bus_a.force_on = 1'b0;
    bus_a.scan_en  = 1'b0;
    tick(3);

    // t0: reset state
    cur_test = 0;
    expect_at(0, SigE, 0);
    expect_at(0, SigAck, 0);
    expect_at(0, SigTe, 0);
    expect_at(0, SigCnt, 0);
    expect_at(0, SigE0, 0);
    rst = 1'b0;
    tick(2);

    // t1: single-cycle req pulse; zero-wake build opens with ack on the same edge
    cur_test = 1;
    bus_a.req = 1'b1;
    expect_at(0, SigE, 0);
    expect_at(1, SigE, 1);
    expect_at(0, SigAck0, 0);
    expect_at(1, SigE0, 1);
    expect_at(1, SigAck0, 1);
    tick(1);
    bus_a.req = 1'b0;
    expect_at(1, SigAck, 0);
    expect_at(2, SigAck, 1);
    expect_at(6, SigE, 1);
    expect_at(6, SigCnt, 0);
    expect_at(7, SigE, 0);
    expect_at(7, SigAck, 0);
    expect_at(7, SigCnt, 1);
    tick(9);

    // t2: req held 20 cycles then busy 3 cycles; busy alone afterwards must not wake
    cur_test = 2;
    bus_a.req = 1'b1;
    expect_at(1, SigE, 1);
    tick(20);
    expect_at(0, SigE, 1);
    expect_at(0, SigAck, 1);
    bus_a.req  = 1'b0;
    bus_a.busy = 1'b1;
    tick(3);
    expect_at(0, SigE, 1);
    bus_a.busy = 1'b0;
    expect_at(4, SigE, 1);
    expect_at(5, SigE, 0);
    expect_at(5, SigCnt, 2);
    tick(6);
    bus_a.busy = 1'b1;
    expect_at(1, SigE, 0);
    expect_at(3, SigE, 0);
    tick(3);
    bus_a.busy = 1'b0;
    tick(1);

    // t3: req returns exactly when drain would expire
    cur_test = 3;
    bus_a.req = 1'b1;
    tick(3);
    bus_a.req = 1'b0;
    tick(4);
    bus_a.req = 1'b1;
    expect_at(1, SigE, 1);
    expect_at(1, SigAck, 1);
    expect_at(1, SigCnt, 2);
    tick(1);
    bus_a.req = 1'b0;
    expect_at(4, SigE, 1);
    expect_at(4, SigCnt, 2);
    expect_at(5, SigE, 0);
    expect_at(5, SigCnt, 3);
    tick(7);

    // t4: reset in the second wake cycle, then a full wake restarts
    cur_test = 4;
    bus_a.req = 1'b1;
    tick(1);
    rst = 1'b1;
    expect_at(0, SigE, 1);
    expect_at(1, SigE, 0);
    expect_at(1, SigAck, 0);
    expect_at(1, SigCnt, 0);
    tick(1);
    rst = 1'b0;
    expect_at(1, SigE, 1);
    expect_at(2, SigAck, 0);
    expect_at(3, SigAck, 1);
    tick(1);
    bus_a.req = 1'b0;
    expect_at(6, SigE, 1);
    expect_at(7, SigE, 0);
    expect_at(7, SigCnt, 1);
    tick(9);

    // t5: scan enable in OFF only moves te, one edge late
    cur_test = 5;
    bus_a.scan_en = 1'b1;
    expect_at(0, SigTe, 0);
    expect_at(1, SigTe, 1);
    expect_at(1, SigE, 0);
    tick(1);
    bus_a.scan_en = 1'b0;
    expect_at(1, SigTe, 0);
    expect_at(1, SigE, 0);
    tick(2);

    // t6: force_on opens and holds the gate
    cur_test = 6;
    bus_a.force_on = 1'b1;
    expect_at(1, SigE, 1);
    expect_at(3, SigAck, 1);
    tick(5);
    expect_at(0, SigE, 1);
    bus_a.force_on = 1'b0;
    expect_at(5, SigE, 0);
    expect_at(5, SigCnt, 2);
    tick(7);

    // t7: 300 pulse/idle sequences saturate the counter at 255
    cur_test = 7;
    for (int i = 1; i <= 300; i++) begin
      bus_a.req = 1'b1;
      tick(1);
      bus_a.req = 1'b0;
      tick(9);
      if (i == 100) expect_at(0, SigCnt, 102);
      if (i == 253) expect_at(0, SigCnt, 255);
      if (i == 254) expect_at(0, SigCnt, 255);
      if (i == 300) expect_at(0, SigCnt, 255);
    end
    expect_at(1, SigE, 0);

    for (int i = 0; i < 50 && sb.size() > 0; i++) tick(1);
    if (sb.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d expectations never checked, expected 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
